// File: rtl/seq_fsm_pkg.sv
// Shared types and defaults for the sequence-detector front end.
// The serializer state enum and parameter defaults live here.
package seq_fsm_pkg;

   typedef enum logic [0:0] {SER_IDLE, SER_SHIFT} ser_state_t;

   localparam int   DEF_WIDTH      = 8;
   localparam bit   DEF_MSB_FIRST  = 1'b1;
   localparam logic DEF_IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/ser_hold_buf.sv
// One-entry hold buffer that lets the next word wait while the current one shifts.
// ready_o is derived from the registered full flag only.
module ser_hold_buf #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load_i,
   input  logic             drain_i,
   input  logic [WIDTH-1:0] data_i,
   output logic [WIDTH-1:0] data_o,
   output logic             full_o,
   output logic             ready_o
);

   logic [WIDTH-1:0] data_q;
   logic             full_q;

   // load and drain are mutually exclusive: load needs ready, drain needs full
   always_ff @(posedge clk) begin
      if (reset) begin
         data_q <= '0;
         full_q <= 1'b0;
      end else if (load_i) begin
         data_q <= data_i;
         full_q <= 1'b1;
      end else if (drain_i) begin
         full_q <= 1'b0;
      end
   end

   assign data_o  = data_q;
   assign full_o  = full_q;
   assign ready_o = !full_q;

endmodule

// File: rtl/seq_bit_serializer.sv
// Parallel-to-serial front end: words in over valid/ready, one bit per clock out
// on ser_bit; the line rests at IDLE_LEVEL whenever no data bit is presented.
module seq_bit_serializer
   import seq_fsm_pkg::*;
#(
   parameter int   WIDTH      = DEF_WIDTH,
   parameter bit   MSB_FIRST  = DEF_MSB_FIRST,
   parameter logic IDLE_LEVEL = DEF_IDLE_LEVEL
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             stall,
   output logic             ser_bit,
   output logic             ser_valid,
   output logic             ser_last,
   output logic             busy,
   output ser_state_t       dbg_st
);

   // Handshake: a word transfers on a rising edge where in_valid && in_ready.
   // in_ready depends on registered state only, never on in_valid.

   localparam int            CW       = $clog2(WIDTH);
   localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

   ser_state_t       st_q, st_d;
   logic [WIDTH-1:0] sreg_q, sreg_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             accept, last_bit, shift_out;
   logic             hb_load, hb_drain, hfull;
   logic [WIDTH-1:0] hdata;

   ser_hold_buf #(.WIDTH(WIDTH)) u_hold (
      .clk     (clk),
      .reset   (reset),
      .load_i  (hb_load),
      .drain_i (hb_drain),
      .data_i  (in_data),
      .data_o  (hdata),
      .full_o  (hfull),
      .ready_o (in_ready)
   );

   assign accept    = in_valid && in_ready;
   assign shift_out = MSB_FIRST ? sreg_q[WIDTH-1] : sreg_q[0];
   assign ser_valid = (st_q == SER_SHIFT) && !stall;
   assign ser_bit   = ser_valid ? shift_out : IDLE_LEVEL;
   assign last_bit  = ser_valid && (cnt_q == CNT_LAST);
   assign ser_last  = last_bit;
   assign busy      = (st_q == SER_SHIFT) || hfull;
   assign dbg_st    = st_q;

   always_comb begin
      st_d     = st_q;
      sreg_d   = sreg_q;
      cnt_d    = cnt_q;
      hb_load  = 1'b0;
      hb_drain = 1'b0;
      case (st_q)
         SER_IDLE: begin
            if (accept) begin
               sreg_d = in_data;
               cnt_d  = '0;
               st_d   = SER_SHIFT;
            end
         end
         SER_SHIFT: begin
            if (last_bit) begin
               // Held word has priority; a same-edge handshake only lands here when empty
               if (hfull) begin
                  sreg_d   = hdata;
                  cnt_d    = '0;
                  hb_drain = 1'b1;
               end else if (accept) begin
                  sreg_d = in_data;
                  cnt_d  = '0;
               end else begin
                  st_d = SER_IDLE;
               end
            end else begin
               hb_load = accept;
               if (ser_valid) begin
                  sreg_d = MSB_FIRST ? {sreg_q[WIDTH-2:0], 1'b0}
                                     : {1'b0, sreg_q[WIDTH-1:1]};
                  cnt_d  = cnt_q + CW'(1);
               end
            end
         end
         default: st_d = SER_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         st_q   <= SER_IDLE;
         sreg_q <= '0;
         cnt_q  <= '0;
      end else begin
         st_q   <= st_d;
         sreg_q <= sreg_d;
         cnt_q  <= cnt_d;
      end
   end

endmodule

// File: tb/tb_seq_bit_serializer.sv
// Bench for seq_bit_serializer: an MSB-first and an LSB-first instance share the
// same stimulus; accepted words expand into expected bit streams checked per cycle.
module tb_seq_bit_serializer;
   import seq_fsm_pkg::*;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         reset;
   logic [W-1:0] in_data;
   logic         in_valid;
   logic         stall_dir, stall_rnd, stall;
   bit           stall_en;

   logic         in_ready_m, ser_bit_m, ser_valid_m, ser_last_m, busy_m;
   logic         in_ready_l, ser_bit_l, ser_valid_l, ser_last_l, busy_l;
   ser_state_t   dbg_st_m, dbg_st_l;

   int vectors     = 0;
   int miscompares = 0;

   // each entry is {last, bit}
   logic [1:0] exp_m_q[$];
   logic [1:0] exp_l_q[$];

   assign stall = stall_dir | stall_rnd;

   always #5 clk = ~clk;

   seq_bit_serializer #(.WIDTH(W), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b1)) dut_m (
      .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
      .in_ready(in_ready_m), .stall(stall), .ser_bit(ser_bit_m),
      .ser_valid(ser_valid_m), .ser_last(ser_last_m), .busy(busy_m), .dbg_st(dbg_st_m)
   );

   seq_bit_serializer #(.WIDTH(W), .MSB_FIRST(1'b0), .IDLE_LEVEL(1'b1)) dut_l (
      .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
      .in_ready(in_ready_l), .stall(stall), .ser_bit(ser_bit_l),
      .ser_valid(ser_valid_l), .ser_last(ser_last_l), .busy(busy_l), .dbg_st(dbg_st_l)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic void push_word(input logic [W-1:0] w);
      for (int i = 0; i < W; i++) begin
         exp_m_q.push_back({(i == W - 1), w[W-1-i]});
         exp_l_q.push_back({(i == W - 1), w[i]});
      end
   endfunction

   // Monitor: the pending-bit count alone determines every expected output.
   always @(negedge clk) begin
      logic [1:0] e;
      if (reset) begin
         exp_m_q.delete();
         exp_l_q.delete();
      end else begin
         chk("busy_m", 32'(busy_m), 32'(exp_m_q.size() > 0));
         chk("ready_m", 32'(in_ready_m), 32'(exp_m_q.size() <= W));
         chk("state_m", 32'(dbg_st_m), 32'((exp_m_q.size() > 0) ? SER_SHIFT : SER_IDLE));
         chk("valid_m", 32'(ser_valid_m), 32'((exp_m_q.size() > 0) && !stall));
         if ((exp_m_q.size() > 0) && !stall) begin
            e = exp_m_q.pop_front();
            chk("bit_m", 32'(ser_bit_m), 32'(e[0]));
            chk("last_m", 32'(ser_last_m), 32'(e[1]));
         end else begin
            chk("idle_bit_m", 32'(ser_bit_m), 32'(1));
            chk("idle_last_m", 32'(ser_last_m), 32'(0));
         end

         chk("busy_l", 32'(busy_l), 32'(exp_l_q.size() > 0));
         chk("ready_l", 32'(in_ready_l), 32'(exp_l_q.size() <= W));
         chk("valid_l", 32'(ser_valid_l), 32'((exp_l_q.size() > 0) && !stall));
         if ((exp_l_q.size() > 0) && !stall) begin
            e = exp_l_q.pop_front();
            chk("bit_l", 32'(ser_bit_l), 32'(e[0]));
            chk("last_l", 32'(ser_last_l), 32'(e[1]));
         end else begin
            chk("idle_bit_l", 32'(ser_bit_l), 32'(1));
            chk("idle_last_l", 32'(ser_last_l), 32'(0));
         end

         if (in_valid && in_ready_m) push_word(in_data);
      end
   end

   initial begin
      stall_rnd = 1'b0;
      forever begin
         @(posedge clk);
         #2;
         stall_rnd = stall_en && ($urandom_range(0, 3) == 0);
      end
   end

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [W-1:0] w);
      bit got;
      got      = 1'b0;
      in_data  = w;
      in_valid = 1'b1;
      for (int k = 0; k < 200; k++) begin
         @(negedge clk);
         if (in_ready_m) begin
            got = 1'b1;
            break;
         end
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      if (!got) begin
         vectors++;
         miscompares++;
         $display("FAIL send_timeout: word %0h not accepted within 200 cycles", w);
      end
   endtask

   task automatic wait_drain();
      bit done;
      done = 1'b0;
      for (int k = 0; k < 400; k++) begin
         idle(1);
         if (exp_m_q.size() == 0 && exp_l_q.size() == 0) begin
            done = 1'b1;
            break;
         end
      end
      if (!done) begin
         vectors++;
         miscompares++;
         $display("FAIL drain_timeout: %0d bits still pending", exp_m_q.size());
      end
   endtask

   initial begin
      reset     = 1'b1;
      in_valid  = 1'b0;
      in_data   = '0;
      stall_dir = 1'b0;
      stall_en  = 1'b0;
      idle(2);
      // handshake presented during reset must be ignored
      in_valid = 1'b1;
      in_data  = 8'hFF;
      idle(1);
      reset    = 1'b0;
      in_valid = 1'b0;
      idle(2);

      // basic MSB-first word
      send(8'b0101_0011);
      wait_drain();
      idle(2);

      // back-to-back words through the hold buffer
      send(8'hA5);
      send(8'h3C);
      wait_drain();
      idle(1);

      // stall after bit 4
      send(8'hF0);
      idle(4);
      stall_dir = 1'b1;
      idle(3);
      stall_dir = 1'b0;
      wait_drain();
      idle(1);

      // reset mid-word with a word held
      send(8'h11);
      send(8'h22);
      idle(2);
      reset = 1'b1;
      idle(1);
      reset = 1'b0;
      idle(4);

      // single low bit, exercises LSB-first ordering
      send(8'h01);
      wait_drain();
      idle(1);

      // same-edge reload on the last bit with the hold buffer empty
      send(8'h55);
      idle(7);
      send(8'h0F);
      wait_drain();
      idle(2);

      // randomized words, gaps and stalls
      stall_en = 1'b1;
      for (int n = 0; n < 40; n++) begin
         idle($urandom_range(0, 3) == 0 ? $urandom_range(1, 10) : 0);
         send(W'($urandom));
      end
      wait_drain();
      stall_en = 1'b0;
      idle(3);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/seq_bit_serializer.md
Name: seq_bit_serializer

Overview:
Parallel-to-serial front end for the sequence-detector FSMs. It accepts WIDTH-bit words over a valid/ready handshake and shifts them out one bit per clock on ser_bit, which drives the detector's serial input A directly. When no word is being shifted, the line is held at a programmable idle level so the detector sees no spurious bits. A one-entry hold buffer allows back-to-back words to stream with no gap.

Parameters:
WIDTH, 8, word width in bits; legal range is WIDTH >= 2.
MSB_FIRST, 1, selects bit order: 1 = bit WIDTH-1 goes out first, 0 = bit 0 goes out first.
IDLE_LEVEL, 1'b1, value driven on ser_bit whenever ser_valid = 0.

Ports:
clk  input  1  clock, all state updates on the rising edge
reset  input  1  reset, synchronous, active-high
in_data  input  WIDTH  word to serialize
in_valid  input  1  in_data is valid this cycle
in_ready  output  1  block can accept a word this cycle
stall  input  1  freezes shifting while high
ser_bit  output  1  serial bit, feeds the detector's A input
ser_valid  output  1  ser_bit carries a data bit this cycle
ser_last  output  1  high with the final bit of each word
busy  output  1  a word is shifting or held

Behaviour:
- State register st takes two values: SER_IDLE and SER_SHIFT.
- Datapath registers:
  - shift register sreg, WIDTH bits.
  - bit counter cnt, $clog2(WIDTH) bits.
  - hold register hreg plus flag hfull.
- Reset (synchronous): st = SER_IDLE, hfull = 0, cnt = 0. Any word in flight and any held word are discarded; no partial word continues after reset.
- Output values in reset and in the cycle after reset: ser_valid = 0, ser_bit = IDLE_LEVEL, ser_last = 0, busy = 0, in_ready = 1.
- Handshakes presented during the reset cycle are ignored.
- in_ready = !hfull, combinational from registered state only. It has no dependence on in_valid.
- Accept: a handshake occurs when in_valid && in_ready is true at a rising edge.
- Accept while in SER_IDLE:
  - in_data loads into sreg, cnt = 0, st goes to SER_SHIFT.
  - The first bit appears in the cycle after the accepting edge, so latency is 1 cycle.
  - stall does not block the load.
- Accept while in SER_SHIFT: the word goes to hreg and hfull = 1.
- SER_SHIFT with stall = 0:
  - ser_valid = 1.
  - ser_bit = sreg[WIDTH-1] when MSB_FIRST = 1, otherwise sreg[0].
  - At the edge, sreg shifts by one toward the output end and cnt increments.
- SER_SHIFT with stall = 1:
  - ser_valid = 0 and ser_bit = IDLE_LEVEL.
  - sreg and cnt hold their values.
  - Handshakes into hreg are still accepted.
- ser_last = ser_valid && (cnt == WIDTH-1).
- On the last-bit edge (ser_last = 1), exactly one of the following applies:
  - hfull = 1: hreg moves into sreg, hfull = 0, cnt = 0, st stays SER_SHIFT. No gap between words.
  - hfull = 0 and a handshake occurs on the same edge: in_data loads directly into sreg, cnt = 0, st stays SER_SHIFT. No gap between words.
  - Neither: st goes to SER_IDLE.
- In SER_IDLE: ser_valid = 0 and ser_bit = IDLE_LEVEL.
- busy = (st == SER_SHIFT) || hfull.
- ser_bit, ser_valid and ser_last are combinational from registers and stall. No output depends on in_valid or in_data.

Decomposition:
- Package seq_fsm_pkg holds:
  - typedef enum logic [0:0] ser_state_t {SER_IDLE, SER_SHIFT};
  - localparam defaults for WIDTH and IDLE_LEVEL.
- Sub-module ser_hold_buf contains the one-entry hold register with its full flag, load/drain controls and in_ready generation. The top level keeps the FSM, shift register and counter.

Test Plan:
1. Basic word, MSB first: reset, then accept 8'b0101_0011. Expect ser_bit = 0,1,0,1,0,0,1,1 on cycles 1–8 after the accept, ser_last on cycle 8 only, then ser_valid = 0 and ser_bit = 1. A downstream detector's Y pulses after bits 2, 4 and 8.
2. Back-to-back words: hold in_valid high with 8'hA5 then 8'h3C. Expect 16 contiguous ser_valid cycles, ser_last on bits 8 and 16, and in_ready = 0 while hfull = 1.
3. Stall mid-word: assert stall for 3 cycles after bit 4 of 8'hF0. Expect ser_valid = 0 and ser_bit = 1 during the stall, bit 5 on resume, and the word done 11 cycles after the accept.
4. Reset mid-operation: assert reset after bit 3 with hfull = 1. Next cycle expect ser_valid = 0, ser_bit = 1, busy = 0, in_ready = 1, and no further bits from either word.
5. LSB first: MSB_FIRST = 0, word 8'h01. Expect a 1 followed by seven 0s.
6. Same-edge reload: hfull = 0 and a new word 8'h0F presented exactly on the ser_last cycle. Expect its first bit on the very next cycle with no idle gap.
